// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared pipeline widths, write-back control bundle and reset constants
package wb_stage_pkg;

    localparam int data_width_default = 16;
    localparam int addr_width_default = 3;
    localparam int count_width        = 16;

    typedef struct packed {
        logic valid;
        logic reg_wr;
        logic mem_r;
    } wb_ctrl_t;

    localparam logic [data_width_default-1:0] reg_data_rst = '0;
    localparam logic [addr_width_default-1:0] rw_addr_rst  = '0;

endpackage

// File: rtl/wb_stage_retire_counter.sv
// rtl/wb_stage_retire_counter.sv - wrapping retired-instruction counter with increment enable
module retire_counter
    import wb_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc_en,
    output logic [count_width-1:0] count
);

    logic [count_width-1:0] count_q;
    logic [count_width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + count_width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register and register-file write port
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int width      = data_width_default,
    parameter int addr_width = addr_width_default
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    input  logic                   mem_RegWR,
    input  logic                   mem_MemR,
    input  logic [width-1:0]       mem_alu_result,
    input  logic [width-1:0]       mem_read_data,
    input  logic [addr_width-1:0]  mem_dest_addr,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   wb_valid,
    output logic                   RW_Sig,
    output logic [width-1:0]       Reg_data,
    output logic [addr_width-1:0]  RW_addr,
    output logic [count_width-1:0] retired_count
);

    wb_ctrl_t              mem_ctrl;
    logic                  load;
    logic                  wb_valid_q, wb_valid_d;
    logic                  rw_sig_q, rw_sig_d;
    logic [width-1:0]      reg_data_q, reg_data_d;
    logic [addr_width-1:0] rw_addr_q, rw_addr_d;

    assign mem_ctrl = '{valid: mem_valid, reg_wr: mem_RegWR, mem_r: mem_MemR};
    assign load     = !flush && !stall;

    // Flush beats stall; a stall holds everything, including a pending write.
    always_comb begin
        wb_valid_d = wb_valid_q;
        rw_sig_d   = rw_sig_q;
        reg_data_d = reg_data_q;
        rw_addr_d  = rw_addr_q;
        if (flush) begin
            wb_valid_d = 1'b0;
            rw_sig_d   = 1'b0;
            reg_data_d = width'(reg_data_rst);
            rw_addr_d  = addr_width'(rw_addr_rst);
        end else if (!stall) begin
            wb_valid_d = mem_ctrl.valid;
            rw_sig_d   = mem_ctrl.valid & mem_ctrl.reg_wr;
            reg_data_d = mem_ctrl.mem_r ? mem_read_data : mem_alu_result;
            rw_addr_d  = mem_dest_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            rw_sig_q   <= 1'b0;
            reg_data_q <= width'(reg_data_rst);
            rw_addr_q  <= addr_width'(rw_addr_rst);
        end else begin
            wb_valid_q <= wb_valid_d;
            rw_sig_q   <= rw_sig_d;
            reg_data_q <= reg_data_d;
            rw_addr_q  <= rw_addr_d;
        end
    end

    retire_counter u_retire_counter (
        .clk    (clk),
        .rst_n  (rst),
        .inc_en (load & mem_ctrl.valid),
        .count  (retired_count)
    );

    assign wb_valid = wb_valid_q;
    assign RW_Sig   = rw_sig_q;
    assign Reg_data = reg_data_q;
    assign RW_addr  = rw_addr_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_RegWR;
    logic        mem_MemR;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_read_data;
    logic [2:0]  mem_dest_addr;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic        RW_Sig;
    logic [15:0] Reg_data;
    logic [2:0]  RW_addr;
    logic [15:0] retired_count;

    int checks;
    int errors;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_RegWR      (mem_RegWR),
        .mem_MemR       (mem_MemR),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .mem_dest_addr  (mem_dest_addr),
        .stall          (stall),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .RW_Sig         (RW_Sig),
        .Reg_data       (Reg_data),
        .RW_addr        (RW_addr),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic w,
                              input logic [15:0] d, input logic [2:0] a, input logic [15:0] c);
        check_eq({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
        check_eq({tag, ".RW_Sig"}, 32'(RW_Sig), 32'(w));
        check_eq({tag, ".Reg_data"}, 32'(Reg_data), 32'(d));
        check_eq({tag, ".RW_addr"}, 32'(RW_addr), 32'(a));
        check_eq({tag, ".retired_count"}, 32'(retired_count), 32'(c));
    endtask

    task automatic drive(input logic v, input logic w, input logic r,
                         input logic [15:0] alu, input logic [15:0] rd, input logic [2:0] a);
        mem_valid      = v;
        mem_RegWR      = w;
        mem_MemR       = r;
        mem_alu_result = alu;
        mem_read_data  = rd;
        mem_dest_addr  = a;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        stall  = 1'b1;
        flush  = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 3'h7);
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 16'h0000, 3'h0, 16'h0000);

        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 3'd3);
        rst = 1'b1;
        tick();
        check_outs("first_load", 1'b1, 1'b1, 16'h1234, 3'd3, 16'd1);

        drive(1'b1, 1'b1, 1'b1, 16'h0001, 16'hBEEF, 3'd5);
        tick();
        check_outs("sel_mem", 1'b1, 1'b1, 16'hBEEF, 3'd5, 16'd2);
        drive(1'b1, 1'b1, 1'b0, 16'h0001, 16'hBEEF, 3'd5);
        tick();
        check_outs("sel_alu", 1'b1, 1'b1, 16'h0001, 3'd5, 16'd3);

        drive(1'b1, 1'b0, 1'b1, 16'h0002, 16'h4444, 3'd4);
        tick();
        check_outs("no_write", 1'b1, 1'b0, 16'h4444, 3'd4, 16'd4);
        drive(1'b0, 1'b1, 1'b0, 16'h7777, 16'h0000, 3'd6);
        tick();
        check_outs("bubble", 1'b0, 1'b0, 16'h7777, 3'd6, 16'd4);

        drive(1'b1, 1'b1, 1'b0, 16'hAAAA, 16'h0000, 3'd2);
        tick();
        check_outs("pre_stall", 1'b1, 1'b1, 16'hAAAA, 3'd2, 16'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, i[0], 16'h5555 + 16'(i), 16'h9999, 3'(i + 6));
            tick();
            check_outs($sformatf("stall%0d", i), 1'b1, 1'b1, 16'hAAAA, 3'd2, 16'd5);
        end
        flush = 1'b1;
        tick();
        check_outs("stall_flush", 1'b0, 1'b0, 16'h0000, 3'd0, 16'd5);

        stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h3333, 16'h0000, 3'd1);
        tick();
        check_outs("flush_only", 1'b0, 1'b0, 16'h0000, 3'd0, 16'd5);
        flush = 1'b0;
        tick();
        check_outs("after_flush", 1'b1, 1'b1, 16'h3333, 3'd1, 16'd6);

        rst = 1'b0;
        #1;
        rst = 1'b1;
        check_eq("clr_count", 32'(retired_count), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0000, 3'd7);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        check_eq("count_ffff", 32'(retired_count), 32'hFFFF);
        tick();
        check_eq("count_wrap", 32'(retired_count), 32'h0000);

        check_eq("pre_async.RW_Sig", 32'(RW_Sig), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 16'h0000, 3'd0, 16'h0000);
        tick();
        check_outs("held_rst", 1'b0, 1'b0, 16'h0000, 3'd0, 16'h0000);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'hC0DE, 3'd0);
        tick();
        check_outs("post_rst", 1'b1, 1'b1, 16'hC0DE, 3'd0, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
